// File: rtl/led_cmd_uart_tx.sv
// led_cmd_uart_tx: host-side encoder for the LED panel serial command link.
// Each accepted panel command becomes 1-3 bytes, each sent as 8N1 UART at
// CLKS_PER_BIT clocks per bit. A resync request queues the byte 0xF5, which is
// never inserted inside a command.
// Optional build macro LED_CMD_TX_RESYNC_EN: prefixes every set/clear pixel
// command with 0xF5 so the panel receiver always restarts from control state.
module led_cmd_uart_tx #(
   parameter int CLKS_PER_BIT = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_rgb,
   input  logic [3:0] cmd_x,
   input  logic [3:0] cmd_y,
   input  logic       sync_req,
   output logic       uart_tx,
   output logic       busy,
   output logic       byte_done
);

   localparam logic [7:0] CNT_LAST  = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] CNT_DONE  = 8'(CLKS_PER_BIT - 2);
   localparam logic [7:0] SYNC_BYTE = 8'hF5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic [2:0]  idx_r;
   logic [7:0]  shreg_r;
   logic [7:0]  q0_r;
   logic [7:0]  q1_r;
   logic [7:0]  q2_r;
   logic [1:0]  left_r;
   logic        pend_r;
   logic        tx_r;
   logic        ready_r;
   logic        busy_r;
   logic        done_r;

   logic [7:0]  first_s;
   logic [7:0]  q0_s;
   logic [7:0]  q1_s;
   logic [7:0]  q2_s;
   logic [1:0]  left_s;
   logic        launch_sync_s;

   assign uart_tx   = tx_r;
   assign cmd_ready = ready_r;
   assign busy      = busy_r;
   assign byte_done = done_r;

   // Expand the presented command into its first byte plus the queued followers.
   always_comb begin
      first_s = 8'h00;
      q0_s    = 8'h00;
      q1_s    = 8'h00;
      q2_s    = 8'h00;
      left_s  = 2'd0;
      case (cmd_op)
         2'd0: begin
            first_s = {4'h0, 1'b0, cmd_rgb};
         end
         2'd1, 2'd2: begin
`ifdef LED_CMD_TX_RESYNC_EN
            first_s = SYNC_BYTE;
            q0_s    = {2'b00, cmd_op, 4'h0};
            q1_s    = {4'h0, cmd_x};
            q2_s    = {4'h0, cmd_y};
            left_s  = 2'd3;
`else
            first_s = {2'b00, cmd_op, 4'h0};
            q0_s    = {4'h0, cmd_x};
            q1_s    = {4'h0, cmd_y};
            left_s  = 2'd2;
`endif
         end
         2'd3: begin
            first_s = 8'h30;
         end
         default: begin
            first_s = 8'h00;
         end
      endcase
   end

   // A queued resync byte launches at the end of a command's last stop bit.
   always_comb begin
      if ((state_r == STOP) && (cnt_r == CNT_LAST) && (left_r == 2'd0)) begin
         launch_sync_s = pend_r | sync_req;
      end else begin
         launch_sync_s = 1'b0;
      end
   end

   // Remember a resync request that arrives while a transfer is in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_r <= 1'b0;
      end else if (launch_sync_s) begin
         pend_r <= 1'b0;
      end else if (sync_req && (state_r != IDLE)) begin
         pend_r <= 1'b1;
      end else begin
         pend_r <= pend_r;
      end
   end

   // Byte sequencer and bit serialiser with registered line and status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         idx_r   <= 3'd0;
         shreg_r <= 8'h00;
         q0_r    <= 8'h00;
         q1_r    <= 8'h00;
         q2_r    <= 8'h00;
         left_r  <= 2'd0;
         tx_r    <= 1'b1;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= 8'd0;
               idx_r <= 3'd0;
               if (sync_req) begin
                  shreg_r <= SYNC_BYTE;
                  left_r  <= 2'd0;
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end else if (cmd_valid && ready_r) begin
                  shreg_r <= first_s;
                  q0_r    <= q0_s;
                  q1_r    <= q1_s;
                  q2_r    <= q2_s;
                  left_r  <= left_s;
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end else begin
                  tx_r    <= 1'b1;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            START: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= 8'd0;
                  idx_r   <= 3'd0;
                  state_r <= DATA;
                  tx_r    <= shreg_r[0];
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            DATA: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= 8'd0;
                  if (idx_r == 3'd7) begin
                     state_r <= STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     idx_r <= idx_r + 3'd1;
                     tx_r  <= shreg_r[idx_r + 3'd1];
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            STOP: begin
               if (cnt_r == CNT_DONE) begin
                  done_r <= 1'b1;
               end
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= 8'd0;
                  if (left_r != 2'd0) begin
                     shreg_r <= q0_r;
                     q0_r    <= q1_r;
                     q1_r    <= q2_r;
                     q2_r    <= 8'h00;
                     left_r  <= left_r - 2'd1;
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else if (launch_sync_s) begin
                     shreg_r <= SYNC_BYTE;
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     ready_r <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
